// File: rtl/ddr_tx_serializer.sv
// rtl/ddr_tx_serializer.sv - DDR output serializer: word FIFO feeding a rise/fall lane output stage
module ddr_tx_serializer #(
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH      = 4,
   parameter int IDLE_VALUE = 0,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [2*DATA_WIDTH-1:0] din,
   input  logic                    din_vld,
   output logic                    din_rd,
   output logic [DATA_WIDTH-1:0]   dout,
   output logic                    dout_en,
   output logic [CW-1:0]           count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [DATA_WIDTH-1:0] IDLE_LANE = DATA_WIDTH'(IDLE_VALUE);

   logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic [DATA_WIDTH-1:0]   rise_q, rise_d;
   logic [DATA_WIDTH-1:0]   fall_pre_q, fall_pre_d;
   logic [DATA_WIDTH-1:0]   fall_q;
   logic                    dout_en_q, dout_en_d;
   logic                    push, pop;

   // Ready depends only on registered occupancy, never on a same-cycle pop.
   assign din_rd  = rst_n && (count_q != CW'(DEPTH));
   assign push    = din_vld && din_rd;
   assign pop     = (count_q != '0);
   assign count   = count_q;
   assign dout_en = dout_en_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      count_d    = count_q + CW'(push) - CW'(pop);
      rise_d     = IDLE_LANE;
      fall_pre_d = IDLE_LANE;
      dout_en_d  = 1'b0;
      if (pop) begin
         rise_d     = mem_q[rd_ptr_q][2*DATA_WIDTH-1:DATA_WIDTH];
         fall_pre_d = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
         dout_en_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rise_q     <= IDLE_LANE;
         fall_pre_q <= IDLE_LANE;
         dout_en_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rise_q     <= rise_d;
         fall_pre_q <= fall_pre_d;
         dout_en_q  <= dout_en_d;
      end
   end

   // Retiming the fall lane onto the falling edge keeps it stable through the low phase.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) fall_q <= IDLE_LANE;
      else        fall_q <= fall_pre_q;
   end

   assign dout = clk ? rise_q : fall_q;

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// tb/tb_ddr_tx_serializer.sv - scoreboard bench for ddr_tx_serializer
module tb_ddr_tx_serializer;

   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic            clk = 1'b0;
   logic            rst_n;
   logic [2*W-1:0]  din;
   logic            din_vld;
   logic            din_rd;
   logic [W-1:0]    dout;
   logic            dout_en;
   logic [CW-1:0]   count;

   int              n_cmp  = 0;
   int              n_fail = 0;
   int              mcnt   = 0;
   int              en_cycles = 0;
   logic [2*W-1:0]  exp_q[$];
   logic [2*W-1:0]  obs_q[$];

   ddr_tx_serializer #(.DATA_WIDTH(W), .DEPTH(DEPTH), .IDLE_VALUE(0)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_rd(din_rd),
      .dout(dout), .dout_en(dout_en), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   // Collect each emitted word: rise lane in the high phase, fall lane in the low phase.
   initial begin
      logic [W-1:0] r;
      forever begin
         @(posedge clk);
         #2;
         if (dout_en === 1'b1) begin
            en_cycles++;
            r = dout;
            @(negedge clk);
            #2;
            obs_q.push_back({r, dout});
         end
      end
   end

   task automatic drive_cycle(input logic vld, input logic [2*W-1:0] data);
      logic p, q;
      din     = data;
      din_vld = vld;
      @(posedge clk);
      p = vld && (mcnt != DEPTH);
      q = (mcnt != 0);
      if (p) exp_q.push_back(data);
      mcnt = mcnt + int'(p) - int'(q);
      #1 din_vld = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n   = 1'b0;
      din_vld = 1'b1;
      din     = 16'hFFFF;
      repeat (3) begin
         @(posedge clk);
         #2;
         n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout_high got=%h exp=00", dout); end
         n_cmp++; if (dout_en !== 1'b0) begin n_fail++; $display("FAIL reset_dout_en got=%b exp=0", dout_en); end
         @(negedge clk);
         #2;
         n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout_low got=%h exp=00", dout); end
         n_cmp++; if (din_rd !== 1'b0) begin n_fail++; $display("FAIL reset_din_rd got=%b exp=0", din_rd); end
         n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
      end
      din_vld = 1'b0;
      rst_n   = 1'b1;
      #1;
      n_cmp++; if (din_rd !== 1'b1) begin n_fail++; $display("FAIL release_din_rd got=%b exp=1", din_rd); end
      n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL release_count got=%0d exp=0", count); end
      mcnt = 0;
   endtask

   task automatic test_single;
      logic [2*W-1:0] e, o;
      drive_cycle(1'b1, 16'hA55A);
      n_cmp++; if (count !== CW'(1)) begin n_fail++; $display("FAIL single_count_after_push got=%0d exp=1", count); end
      n_cmp++; if (dout_en !== 1'b0) begin n_fail++; $display("FAIL single_en_early got=%b exp=0", dout_en); end
      @(posedge clk);
      #2;
      n_cmp++; if (dout_en !== 1'b1) begin n_fail++; $display("FAIL single_en got=%b exp=1", dout_en); end
      n_cmp++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL single_rise got=%h exp=a5", dout); end
      @(negedge clk);
      #2;
      n_cmp++; if (dout !== 8'h5A) begin n_fail++; $display("FAIL single_fall got=%h exp=5a", dout); end
      n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL single_count_drain got=%0d exp=0", count); end
      mcnt = 0;
      drive_cycle(1'b0, '0);
      n_cmp++; if (dout_en !== 1'b0) begin n_fail++; $display("FAIL single_en_after got=%b exp=0", dout_en); end
      repeat (3) drive_cycle(1'b0, '0);
      n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_words got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++; if (o !== e) begin n_fail++; $display("FAIL single_word got=%h exp=%h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_stream;
      logic [2*W-1:0] words [4];
      logic [2*W-1:0] e, o;
      words[0] = 16'h0102; words[1] = 16'h0304; words[2] = 16'h0506; words[3] = 16'h0708;
      en_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, words[i]);
         n_cmp++; if (count !== CW'(mcnt) || mcnt > 1) begin n_fail++; $display("FAIL stream_count got=%0d exp=%0d", count, mcnt); end
      end
      repeat (4) drive_cycle(1'b0, '0);
      n_cmp++; if (en_cycles != 4) begin n_fail++; $display("FAIL stream_en_cycles got=%0d exp=4", en_cycles); end
      n_cmp++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL stream_words got=%0d exp=4", obs_q.size()); end
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++; if (o !== e) begin n_fail++; $display("FAIL stream_word got=%h exp=%h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_random_flow;
      logic [2*W-1:0] e, o;
      repeat (1000) begin
         drive_cycle(1'($urandom_range(0, 1)), 16'($urandom));
         n_cmp++; if (din_rd !== (mcnt != DEPTH)) begin n_fail++; $display("FAIL rand_din_rd got=%b cnt=%0d", din_rd, mcnt); end
         n_cmp++; if (count !== CW'(mcnt)) begin n_fail++; $display("FAIL rand_count got=%0d exp=%0d", count, mcnt); end
      end
      repeat (4) drive_cycle(1'b0, '0);
      n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_words got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++; if (o !== e) begin n_fail++; $display("FAIL rand_word got=%h exp=%h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_wrap;
      logic [2*W-1:0] e, o;
      for (int i = 0; i < 3*DEPTH + 1; i++) begin
         drive_cycle(1'b1, 16'h1000 + 16'(i * 16'h0111));
         if (i % 3 == 2) drive_cycle(1'b0, '0);
      end
      repeat (4) drive_cycle(1'b0, '0);
      n_cmp++; if (obs_q.size() != 3*DEPTH + 1) begin n_fail++; $display("FAIL wrap_words got=%0d exp=%0d", obs_q.size(), 3*DEPTH + 1); end
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++; if (o !== e) begin n_fail++; $display("FAIL wrap_word got=%h exp=%h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid;
      logic [2*W-1:0] e, o;
      drive_cycle(1'b1, 16'h3344);
      din     = 16'h5566;
      din_vld = 1'b1;
      @(posedge clk);
      #1 din_vld = 1'b0;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL midrst_dout_high got=%h exp=00", dout); end
      n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", count); end
      n_cmp++; if (dout_en !== 1'b0) begin n_fail++; $display("FAIL midrst_en got=%b exp=0", dout_en); end
      n_cmp++; if (din_rd !== 1'b0) begin n_fail++; $display("FAIL midrst_din_rd got=%b exp=0", din_rd); end
      @(negedge clk);
      #2;
      n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL midrst_dout_low got=%h exp=00", dout); end
      #1;
      exp_q.delete(); obs_q.delete();
      mcnt  = 0;
      rst_n = 1'b1;
      #1;
      n_cmp++; if (din_rd !== 1'b1) begin n_fail++; $display("FAIL midrst_release_rd got=%b exp=1", din_rd); end
      drive_cycle(1'b1, 16'h1122);
      @(posedge clk);
      #2;
      n_cmp++; if (dout_en !== 1'b1) begin n_fail++; $display("FAIL midrst_en_after got=%b exp=1", dout_en); end
      n_cmp++; if (dout !== 8'h11) begin n_fail++; $display("FAIL midrst_rise got=%h exp=11", dout); end
      @(negedge clk);
      #2;
      n_cmp++; if (dout !== 8'h22) begin n_fail++; $display("FAIL midrst_fall got=%h exp=22", dout); end
      mcnt = 0;
      repeat (3) drive_cycle(1'b0, '0);
      n_cmp++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL midrst_words got=%0d exp=1", obs_q.size()); end
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++; if (o !== e) begin n_fail++; $display("FAIL midrst_word got=%h exp=%h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      din     = '0;
      din_vld = 1'b0;
      rst_n   = 1'b0;
      test_reset();
      test_single();
      test_stream();
      test_random_flow();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
